// File: rtl/game_pkg.sv
// Shared definitions for the tile game: grid geometry, fruit codes and dealer state encoding.
package game_pkg;

  localparam int unsigned NUM_CELLS  = 16;
  localparam int unsigned NUM_IMAGES = 8;
  localparam int unsigned COPIES     = 2;
  localparam int unsigned CELL_W     = 4;
  localparam int unsigned IMG_W      = 3;
  // Slot counts 0..NUM_CELLS inclusive, so it needs one bit more than a cell index.
  localparam int unsigned SLOT_W     = 5;
  localparam int unsigned CNT_W      = 2;

  typedef logic [IMG_W-1:0] img_t;

  localparam img_t AVOCADO    = 3'd0;
  localparam img_t APPLE      = 3'd1;
  localparam img_t COCONUT    = 3'd2;
  localparam img_t KIWI       = 3'd3;
  localparam img_t LEMON      = 3'd4;
  localparam img_t PEACH      = 3'd5;
  localparam img_t PEAR       = 3'd6;
  localparam img_t WATERMELON = 3'd7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StDeal = 2'd1,
    StDone = 2'd2
  } dealer_state_e;

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1; a zero seed is replaced by 1.
module lfsr8 (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] seed_i,
  output logic [7:0] out_o
);

  logic [7:0] lfsr_q, lfsr_d;
  logic       fb;

  // Next value: shift left, feed back the tap parity into bit 0.
  always_comb begin
    fb     = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    lfsr_d = {lfsr_q[6:0], fb};
  end

  // State register; an all-zero seed would lock the sequence, so load 1 instead.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= (seed_i == 8'h00) ? 8'h01 : seed_i;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign out_o = lfsr_q;

endmodule

// File: rtl/board_dealer.sv
// Deals a 4x4 board with every fruit code placed exactly twice, in LFSR-driven order,
// and serves the finished board to the drawing stage through a combinational read port.
module board_dealer
  import game_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [CELL_W-1:0] rd_index_i,
  output logic [IMG_W-1:0]  rd_image_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              done_pulse_o,
  output logic [SLOT_W-1:0] slot_o
);

  dealer_state_e     state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [CNT_W-1:0]  count_q [NUM_IMAGES];
  logic [CNT_W-1:0]  count_d [NUM_IMAGES];
  img_t              board_q [NUM_CELLS];
  img_t              board_d [NUM_CELLS];
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pulse_q, pulse_d;

  logic [7:0]            lfsr_out;
  logic                  unused_lfsr_bits;
  img_t                  cand;
  img_t                  fallback;
  img_t                  pick;
  logic [NUM_IMAGES-1:0] free;

  lfsr8 u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .seed_i (SEED),
    .out_o  (lfsr_out)
  );

  // Only the low bits choose a candidate fruit.
  assign unused_lfsr_bits = ^lfsr_out[7:IMG_W];

  // Pick: the LFSR candidate if it still has a free copy, else the lowest code with one.
  always_comb begin
    cand     = lfsr_out[IMG_W-1:0];
    fallback = AVOCADO;
    for (int i = 0; i < int'(NUM_IMAGES); i++) begin
      free[i] = (count_q[i] < CNT_W'(COPIES));
    end
    for (int i = int'(NUM_IMAGES) - 1; i >= 0; i--) begin
      if (free[i]) begin
        fallback = IMG_W'(i);
      end
    end
    pick = free[cand] ? cand : fallback;
  end

  // Next-state logic: accept start when idle/done, otherwise fill one cell per cycle.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    count_d = count_q;
    board_d = board_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pulse_d = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d = StDeal;
          slot_d  = '0;
          for (int i = 0; i < int'(NUM_IMAGES); i++) begin
            count_d[i] = '0;
          end
          for (int i = 0; i < int'(NUM_CELLS); i++) begin
            board_d[i] = AVOCADO;
          end
          busy_d = 1'b1;
          done_d = 1'b0;
        end
      end
      StDeal: begin
        board_d[slot_q[CELL_W-1:0]] = pick;
        count_d[pick]               = count_q[pick] + CNT_W'(1);
        slot_d                      = slot_q + SLOT_W'(1);
        if (slot_q == SLOT_W'(NUM_CELLS - 1)) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pulse_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and board registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      slot_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pulse_q <= 1'b0;
      for (int i = 0; i < int'(NUM_IMAGES); i++) begin
        count_q[i] <= '0;
      end
      for (int i = 0; i < int'(NUM_CELLS); i++) begin
        board_q[i] <= AVOCADO;
      end
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pulse_q <= pulse_d;
      count_q <= count_d;
      board_q <= board_d;
    end
  end

  assign rd_image_o   = board_q[rd_index_i];
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign done_pulse_o = pulse_q;
  assign slot_o       = slot_q;

endmodule

// File: tb/tb_board_dealer.sv
// Bench for board_dealer: directed deal scenarios plus a cycle-level reference model.
module tb_board_dealer;
  import game_pkg::*;

  logic       clk        = 1'b0;
  logic       reset      = 1'b1;
  logic       start_i    = 1'b0;
  logic [3:0] rd_index_i = 4'd0;
  logic [2:0] rd_image_o, rd_image0;
  logic       busy_o, done_o, done_pulse_o;
  logic       busy0, done0, pulse0;
  logic [4:0] slot_o, slot0;

  always #50 clk = ~clk;

  board_dealer #(.SEED(8'h01)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .rd_index_i   (rd_index_i),
    .rd_image_o   (rd_image_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .done_pulse_o (done_pulse_o),
    .slot_o       (slot_o)
  );

  // A zero seed must behave exactly like seed 1.
  board_dealer #(.SEED(8'h00)) u_dut_zero (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .rd_index_i   (rd_index_i),
    .rd_image_o   (rd_image0),
    .busy_o       (busy0),
    .done_o       (done0),
    .done_pulse_o (pulse0),
    .slot_o       (slot0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model state.
  logic [7:0] m_lfsr = 8'h01;
  int         m_state = 0;  // 0 idle, 1 deal, 2 done
  int         m_slot  = 0;
  int         m_cnt [8] = '{default: 0};
  logic [2:0] m_board [16] = '{default: 3'd0};
  logic       m_busy = 1'b0, m_done = 1'b0, m_pulse = 1'b0, m_fb = 1'b0;
  int         fb_hits = 0;

  task automatic model_step();
    logic [2:0] cand, pick;
    if (reset) begin
      m_lfsr  = 8'h01;
      m_state = 0;
      m_slot  = 0;
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      for (int i = 0; i < 16; i++) m_board[i] = 3'd0;
      m_busy = 1'b0; m_done = 1'b0; m_pulse = 1'b0; m_fb = 1'b0;
    end else begin
      cand    = m_lfsr[2:0];
      m_pulse = 1'b0;
      m_fb    = 1'b0;
      if (m_state != 1) begin
        if (start_i) begin
          m_state = 1;
          m_slot  = 0;
          for (int i = 0; i < 8; i++) m_cnt[i] = 0;
          for (int i = 0; i < 16; i++) m_board[i] = 3'd0;
          m_busy = 1'b1;
          m_done = 1'b0;
        end
      end else begin
        pick = cand;
        if (m_cnt[cand] >= 2) begin
          m_fb = 1'b1;
          fb_hits++;
          for (int c = 7; c >= 0; c--) if (m_cnt[c] < 2) pick = 3'(c);
        end
        m_board[m_slot] = pick;
        m_cnt[pick]++;
        m_slot++;
        if (m_slot == 16) begin
          m_state = 2; m_busy = 1'b0; m_done = 1'b1; m_pulse = 1'b1;
        end
      end
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  endtask

  // One clock: advance the model, then compare outputs and the most recently written cell.
  task automatic tick();
    int idx;
    @(posedge clk);
    model_step();
    #1;
    idx = (m_slot == 0) ? 0 : m_slot - 1;
    rd_index_i = 4'(idx);
    #1;
    check_eq("busy", 32'(busy_o), 32'(m_busy));
    check_eq("done", 32'(done_o), 32'(m_done));
    check_eq("done_pulse", 32'(done_pulse_o), 32'(m_pulse));
    check_eq("slot", 32'(slot_o), 32'(m_slot));
    check_eq(m_fb ? "fallback_pick" : "image", 32'(rd_image_o), 32'(m_board[idx]));
    check_eq("zero_seed_image", 32'(rd_image0), 32'(m_board[idx]));
    check_eq("zero_seed_slot", 32'(slot0), 32'(m_slot));
    check_eq("zero_seed_done", 32'(done0), 32'(m_done));
  endtask

  task automatic reset_dut();
    reset   = 1'b1;
    start_i = 1'b1;  // reset must win over start
    tick();
    start_i = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic start_deal(input int delay);
    repeat (delay) tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check_eq("accept_busy", 32'(busy_o), 32'd1);
    check_eq("accept_done_low", 32'(done_o), 32'd0);
    check_eq("accept_slot", 32'(slot_o), 32'd0);
  endtask

  // Wait for completion with a cycle bound; optionally re-pulse start at DEAL cycles r1/r2.
  task automatic wait_done(input int r1, input int r2, input string tag);
    int lat = 0;
    int busy_n;
    int pulses = 0;
    busy_n = int'(busy_o);
    while (lat < 40 && done_o !== 1'b1) begin
      tick();
      lat++;
      start_i = (lat == r1 || lat == r2);
      busy_n += int'(busy_o);
      pulses += int'(done_pulse_o);
    end
    start_i = 1'b0;
    check_eq({tag, "_latency"}, 32'(lat), 32'd16);
    check_eq({tag, "_busy_cycles"}, 32'(busy_n), 32'd16);
    check_eq({tag, "_pulse_count"}, 32'(pulses), 32'd1);
    tick();
    check_eq({tag, "_pulse_clear"}, 32'(done_pulse_o), 32'd0);
    check_eq({tag, "_done_held"}, 32'(done_o), 32'd1);
  endtask

  task automatic check_legal(input string tag, output logic [47:0] b);
    int cnt [8];
    for (int c = 0; c < 8; c++) cnt[c] = 0;
    b = '0;
    for (int i = 0; i < 16; i++) begin
      rd_index_i = 4'(i);
      #1;
      b[i*3 +: 3] = rd_image_o;
      check_eq({tag, "_cell"}, 32'(rd_image_o), 32'(m_board[i]));
      if (!$isunknown(rd_image_o)) cnt[rd_image_o]++;
    end
    for (int c = 0; c < 8; c++) check_eq({tag, "_code_count"}, 32'(cnt[c]), 32'd2);
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_index_i = 4'(i);
      #1;
      check_eq(tag, 32'(rd_image_o), 32'd0);
    end
  endtask

  logic [47:0] b1, b2, b3, bx;

  initial begin
    reset_dut();
    check_eq("reset_busy", 32'(busy_o), 32'd0);
    check_eq("reset_done", 32'(done_o), 32'd0);
    check_eq("reset_pulse", 32'(done_pulse_o), 32'd0);
    check_eq("reset_slot", 32'(slot_o), 32'd0);
    check_zero("reset_cell");

    // First deal, start two cycles after reset.
    start_deal(2);
    wait_done(0, 0, "first");
    check_legal("first", b1);

    // Same start cycle after reset gives the same board; a later start gives another.
    reset_dut();
    start_deal(2);
    wait_done(0, 0, "repeat");
    check_legal("repeat", b2);
    check_eq("same_start_same_board", 32'(b2 == b1), 32'd1);
    reset_dut();
    start_deal(5);
    wait_done(0, 0, "delayed");
    check_legal("delayed", b3);
    check_eq("later_start_new_board", 32'(b3 != b1), 32'd1);

    // start during DEAL is ignored.
    start_deal(1);
    wait_done(5, 10, "repulse");
    check_legal("repulse", bx);

    // Reset in the middle of a deal discards it.
    start_deal(0);
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("abort_busy", 32'(busy_o), 32'd0);
    check_eq("abort_done", 32'(done_o), 32'd0);
    check_eq("abort_slot", 32'(slot_o), 32'd0);
    check_zero("abort_cell");
    start_deal(3);
    wait_done(0, 0, "after_abort");
    check_legal("after_abort", bx);

    // Re-deal from DONE clears the board on the accepting edge.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check_eq("redeal_done_low", 32'(done_o), 32'd0);
    check_eq("redeal_busy", 32'(busy_o), 32'd1);
    check_zero("redeal_cell");
    wait_done(0, 0, "redeal");
    check_legal("redeal", bx);

    // Many deals with random start delays.
    for (int d = 0; d < 200; d++) begin
      start_deal(int'($urandom_range(0, 4)));
      wait_done(0, 0, "random");
      check_legal("random", bx);
    end
    check_eq("fallback_seen", 32'(fb_hits > 0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
